// File: rtl/nes_pkg.sv
// Shared NES definitions: sprite-DMA state encoding and fixed bus addresses.
package nes_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StHalt,
      StAlign,
      StRead,
      StWrite
   } dma_state_t;

   localparam logic [15:0] DMA_REG_ADDR_C  = 16'h4014;
   localparam logic [15:0] OAM_DATA_ADDR_C = 16'h2004;

endpackage

// File: rtl/oam_dma.sv
// Sprite-DMA controller: halts the CPU, copies one 256-byte page into OAM and
// otherwise passes CPU bus cycles straight through.
module oam_dma
   import nes_pkg::*;
#(
   parameter logic [15:0] DMA_REG_ADDR  = DMA_REG_ADDR_C,
   parameter logic [15:0] OAM_DATA_ADDR = OAM_DATA_ADDR_C
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_d_out,
   input  logic        cpu_we,
   output logic        cpu_rdy,
   output logic [15:0] bus_addr,
   output logic [7:0]  bus_d_out,
   output logic        bus_we,
   input  logic [7:0]  bus_d_in,
   output logic        dma_busy
);

   dma_state_t state_q, state_d;
   logic [7:0] page_q, idx_q, data_q;
   logic       odd_q;
   logic       trigger;

   assign trigger = cpu_we && (cpu_addr == DMA_REG_ADDR);

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (trigger) state_d = StHalt;
         // Alignment guarantees every READ lands on an even cycle.
         StHalt:  state_d = odd_q ? StRead : StAlign;
         StAlign: state_d = StRead;
         StRead:  state_d = StWrite;
         StWrite: state_d = (idx_q == 8'hFF) ? StIdle : StRead;
         default: state_d = StIdle;
      endcase
   end

   // Datapath: parity, source page, byte index and the byte in flight
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         odd_q  <= 1'b0;
         page_q <= 8'h00;
         idx_q  <= 8'h00;
         data_q <= 8'h00;
      end else begin
         odd_q <= ~odd_q;
         if (state_q == StIdle && trigger) begin
            page_q <= cpu_d_out;
            idx_q  <= 8'h00;
         end
         if (state_q == StRead) begin
            data_q <= bus_d_in;
         end
         if (state_q == StWrite) begin
            idx_q <= idx_q + 8'd1;
         end
      end
   end

   // Outputs: status from registered state only, bus mux on state and CPU inputs
   always_comb begin
      cpu_rdy   = 1'b1;
      dma_busy  = 1'b0;
      bus_addr  = cpu_addr;
      bus_d_out = cpu_d_out;
      bus_we    = cpu_we;
      unique case (state_q)
         StIdle: begin
         end
         StHalt, StAlign: begin
            cpu_rdy  = 1'b0;
            dma_busy = 1'b1;
            bus_we   = 1'b0;
         end
         StRead: begin
            cpu_rdy  = 1'b0;
            dma_busy = 1'b1;
            bus_addr = {page_q, idx_q};
            bus_we   = 1'b0;
         end
         StWrite: begin
            cpu_rdy   = 1'b0;
            dma_busy  = 1'b1;
            bus_addr  = OAM_DATA_ADDR;
            bus_d_out = data_q;
            bus_we    = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_oam_dma.sv
// Randomized bench for oam_dma against a cycle-offset schedule model of the transfer.
module tb_oam_dma;

   logic        clk;
   logic        rst;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_d_out;
   logic        cpu_we;
   logic        cpu_rdy;
   logic [15:0] bus_addr;
   logic [7:0]  bus_d_out;
   logic        bus_we;
   logic [7:0]  bus_d_in;
   logic        dma_busy;

   logic [7:0]  mem [65536];

   int n_checks = 0;
   int n_errors = 0;

   // Model: a transfer is a schedule of cycle offsets k from the HALT cycle.
   bit          m_active;
   logic [7:0]  m_page;
   int          m_k;
   bit          m_align;
   int          m_cyc;
   int          rdy_low;

   oam_dma dut (
      .clk       (clk),
      .rst       (rst),
      .cpu_addr  (cpu_addr),
      .cpu_d_out (cpu_d_out),
      .cpu_we    (cpu_we),
      .cpu_rdy   (cpu_rdy),
      .bus_addr  (bus_addr),
      .bus_d_out (bus_d_out),
      .bus_we    (bus_we),
      .bus_d_in  (bus_d_in),
      .dma_busy  (dma_busy)
   );

   assign bus_d_in = mem[bus_addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Transfer step index j (0..511) of the current cycle, or -1 for HALT/ALIGN.
   function automatic int cur_j();
      int first;
      first = m_align ? 2 : 1;
      return (m_k < first) ? -1 : m_k - first;
   endfunction

   task automatic model_reset();
      m_active = 0;
      m_k      = 0;
      m_cyc    = 0;
      m_page   = 8'h00;
      m_align  = 0;
   endtask

   task automatic compare_cycle();
      int j;
      logic [15:0] src;
      if (!m_active) begin
         check_eq("idle_rdy", cpu_rdy, 1);
         check_eq("idle_busy", dma_busy, 0);
         check_eq("idle_addr", bus_addr, cpu_addr);
         check_eq("idle_dout", bus_d_out, cpu_d_out);
         check_eq("idle_we", bus_we, cpu_we);
      end else begin
         check_eq("dma_rdy", cpu_rdy, 0);
         check_eq("dma_busy", dma_busy, 1);
         j = cur_j();
         if (j < 0) begin
            check_eq("halt_addr", bus_addr, cpu_addr);
            check_eq("halt_we", bus_we, 0);
            if (m_k == 0) check_eq("halt_dout", bus_d_out, cpu_d_out);
         end else begin
            src = {m_page, 8'(j / 2)};
            if (j % 2 == 0) begin
               check_eq("read_addr", bus_addr, src);
               check_eq("read_we", bus_we, 0);
               check_eq("read_odd", dut.odd_q, 0);
            end else begin
               check_eq("write_addr", bus_addr, 16'h2004);
               check_eq("write_we", bus_we, 1);
               check_eq("write_data", bus_d_out, mem[src]);
            end
         end
      end
   endtask

   // One clock: compare mid-cycle, then advance the model at the edge.
   task automatic cycle();
      @(negedge clk);
      compare_cycle();
      if (cpu_rdy === 1'b0) rdy_low++;
      @(posedge clk);
      if (rst) begin
         if (!m_active) begin
            if (cpu_we && cpu_addr == 16'h4014) begin
               m_active = 1;
               m_page   = cpu_d_out;
               m_k      = 0;
               m_align  = ((m_cyc + 1) % 2) == 0;
            end
         end else if (m_k == (m_align ? 2 : 1) + 511) begin
            m_active = 0;
         end else begin
            m_k++;
         end
         m_cyc++;
      end
      #1;
   endtask

   task automatic drive_random_no_trigger();
      cpu_addr  = 16'($urandom);
      cpu_d_out = 8'($urandom);
      cpu_we    = 1'($urandom);
      if (cpu_addr == 16'h4014) cpu_we = 1'b0;
   endtask

   // want_odd: HALT parity to wait for (-1 = trigger at once). abort_read: read number
   // at which reset is pulsed (-1 = none). inject: issue an ignored trigger mid-transfer.
   task automatic run_dma(input logic [7:0] page, input int want_odd, input bit inject,
                          input int abort_read);
      int exp_low;
      int guard;
      if (want_odd >= 0) begin
         while (((m_cyc + 1) % 2) != want_odd) begin
            drive_random_no_trigger();
            cycle();
         end
      end
      exp_low   = ((m_cyc + 1) % 2 == 1) ? 513 : 514;
      rdy_low   = 0;
      cpu_addr  = 16'h4014;
      cpu_d_out = page;
      cpu_we    = 1'b1;
      cycle();
      guard = 0;
      while (m_active && guard < 600) begin
         cpu_addr  = 16'($urandom);
         cpu_d_out = 8'($urandom);
         cpu_we    = 1'($urandom);
         if (inject && m_k == 50) begin
            cpu_addr  = 16'h4014;
            cpu_d_out = 8'h05;
            cpu_we    = 1'b1;
         end
         if (abort_read >= 0 && cur_j() == 2 * abort_read) begin
            cpu_addr = 16'h1234;
            cpu_we   = 1'b1;
            rst      = 1'b0;
            #1;
            check_eq("abort_rdy", cpu_rdy, 1);
            check_eq("abort_busy", dma_busy, 0);
            check_eq("abort_we", bus_we, 1);
            check_eq("abort_addr", bus_addr, 16'h1234);
            model_reset();
            @(posedge clk);
            #1;
            rst = 1'b1;
            return;
         end
         cycle();
         guard++;
      end
      check_eq("dma_timeout", m_active, 0);
      check_eq("rdy_low_cycles", rdy_low, exp_low);
   endtask

   initial begin
      for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
      model_reset();
      rst       = 1'b0;
      cpu_addr  = 16'hBEEF;
      cpu_d_out = 8'h5A;
      cpu_we    = 1'b1;
      #3;
      check_eq("rst_rdy", cpu_rdy, 1);
      check_eq("rst_busy", dma_busy, 0);
      check_eq("rst_addr", bus_addr, 16'hBEEF);
      check_eq("rst_dout", bus_d_out, 8'h5A);
      check_eq("rst_we", bus_we, 1);
      check_eq("rst_idx", dut.idx_q, 0);
      check_eq("rst_odd", dut.odd_q, 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;

      for (int i = 0; i < 1000; i++) begin
         drive_random_no_trigger();
         cycle();
      end

      run_dma(8'h02, 1, 0, -1);
      run_dma(8'h02, 0, 0, -1);
      run_dma(8'hFF, 1, 0, -1);
      check_eq("ff_idx_wrap", dut.idx_q, 0);
      // Trigger in the first IDLE cycle after completion
      run_dma(8'h03, -1, 0, -1);
      run_dma(8'h07, 0, 1, -1);
      check_eq("ignored_page", dut.page_q, 8'h07);
      run_dma(8'h02, 1, 0, 99);
      for (int i = 0; i < 5; i++) begin
         drive_random_no_trigger();
         cycle();
      end
      run_dma(8'h42, 0, 0, -1);
      for (int i = 0; i < 10; i++) begin
         drive_random_no_trigger();
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/oam_dma.md
# oam_dma

Sprite-DMA controller and bus arbiter between the 6502 core (`cpu`) and the system bus. A CPU write to `DMA_REG_ADDR` latches a source page, halts the CPU through `cpu_rdy`, and takes over the bus. It then copies 256 bytes from `{page, 8'h00}..{page, 8'hFF}` to `OAM_DATA_ADDR` as alternating read/write cycles. When the DMA does not own the bus, CPU signals pass straight through.

## Interface
- `DMA_REG_ADDR`, default 16'h4014: CPU write address that triggers DMA; the data byte is the source page.
- `OAM_DATA_ADDR`, default 16'h2004: destination address for every DMA write.
- `clk` input 1: system clock, one CPU cycle per edge.
- `rst` input 1: reset, asynchronous, active-low.
- `cpu_addr` input 16: CPU address.
- `cpu_d_out` input 8: CPU write data.
- `cpu_we` input 1: CPU write strobe.
- `cpu_rdy` output 1: 0 halts the CPU.
- `bus_addr` output 16: arbitrated bus address.
- `bus_d_out` output 8: arbitrated bus write data.
- `bus_we` output 1: arbitrated write strobe.
- `bus_d_in` input 8: bus read data, valid in the same cycle as `bus_addr`.
- `dma_busy` output 1: 1 while any non-IDLE state is active.

## Operation
- States: IDLE, HALT, ALIGN, READ, WRITE.
- `odd` is a parity bit that toggles on every clock. It is 0 after reset.
- IDLE:
  - Bus mirrors the CPU: `bus_addr=cpu_addr`, `bus_d_out=cpu_d_out`, `bus_we=cpu_we`.
  - Trigger is `cpu_we && cpu_addr==DMA_REG_ADDR`. On a trigger:
    - latch `page<=cpu_d_out`;
    - clear `idx<=0`;
    - go to HALT.
  - The trigger write also passes through to the bus.
- HALT:
  - `cpu_rdy=0`; the bus still mirrors the CPU, with `bus_we` forced to 0.
  - If `odd==1`, go to READ, otherwise go to ALIGN.
- ALIGN: `cpu_rdy=0`, bus idle (`bus_we=0`, `bus_addr=cpu_addr`). Go to READ.
- READ:
  - `bus_addr={page,idx}`, `bus_we=0`.
  - Latch `data<=bus_d_in` at the ending edge.
  - Go to WRITE.
- WRITE:
  - `bus_addr=OAM_DATA_ADDR`, `bus_d_out=data`, `bus_we=1`.
  - Then `idx<=idx+1` (8-bit, wraps).
  - If `idx==8'hFF`, go to IDLE, otherwise go to READ.
- READ cycles always fall on `odd==0`, and WRITE cycles always fall on `odd==1`.
- Triggers in any non-IDLE state are ignored; `page` and `idx` are unchanged.
- Page 8'hFF is legal: reads cover FF00..FFFF, with no carry into the page.

## Timing
- Reset values (asserted asynchronously):
  - state=IDLE, `cpu_rdy=1`, `dma_busy=0`;
  - `page=0`, `idx=0`, `data=0`, `odd=0`;
  - bus outputs mirror the CPU inputs.
- Reset asserted mid-transfer aborts immediately. The first cycle after release is IDLE with `cpu_rdy=1`.
- Trigger at cycle N: `cpu_rdy` and `dma_busy` go low at cycle N+1.
- `cpu_rdy` low duration, including HALT and ALIGN:
  - 513 cycles if HALT has `odd==1`;
  - 514 cycles if HALT has `odd==0`.
- `cpu_rdy` returns to 1 in the cycle after the 256th WRITE.
- A new trigger in the first IDLE cycle after completion is accepted.
- `cpu_rdy` and `dma_busy` are decoded from registered state only. There is no combinational path from `cpu_*` to `cpu_rdy`.
- The bus mux is combinational on state and CPU inputs.

## Structure
- Shared package `nes_pkg` holds:
  - `dma_state_t` enum (IDLE, HALT, ALIGN, READ, WRITE);
  - address constants `DMA_REG_ADDR_C` and `OAM_DATA_ADDR_C`, used as parameter defaults.
- Single module with no sub-module. The FSM, the `idx` counter, the parity bit and the bus mux all live together.
- Expected size: about 150 lines.

## Test plan
- Trigger with data 8'h02 while HALT has `odd==1`:
  - `cpu_rdy` is low for exactly 513 cycles;
  - reads hit 0200..02FF in order;
  - 256 writes go to 2004 with matching data from a memory model.
- Same as above but HALT has `odd==0`:
  - one ALIGN cycle is inserted and `cpu_rdy` is low for 514 cycles;
  - every READ lands on `odd==0`.
- Page 8'hFF:
  - last read address is FFFF, followed by the write;
  - returns to IDLE with `idx==0` and no access to 0000.
- CPU write of 8'h05 to 4014 while a DMA is active: ignored, and the transfer completes from the original page.
- `rst` pulsed low at the 100th READ:
  - `cpu_rdy=1` and `bus_we` mirrors `cpu_we` immediately;
  - a fresh trigger afterwards performs a full 256-byte transfer.
- IDLE pass-through: random CPU addr/data/we over 1000 cycles with no trigger; bus outputs equal CPU inputs every cycle.
